// File: rtl/mul_arb_pkg.sv
// Shared widths and types for the multiplier arbiter.
// Operands are NUM_ELEMENTS redundant limbs of BIT_LEN bits, weighted 2^(WORD_LEN*i).
// Products carry NUM_OUT limbs of the same width and weighting.
package mul_arb_pkg;

  localparam int unsigned NUM_ELEMENTS = 17;
  localparam int unsigned BIT_LEN      = 17;
  localparam int unsigned WORD_LEN     = 16;
  localparam int unsigned NUM_OUT      = 2 * NUM_ELEMENTS + 1;

  typedef logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0] operand_t;
  typedef logic [NUM_OUT-1:0][BIT_LEN-1:0]      product_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority search, purely combinational.
// Ports:
//   req    - request vector
//   ptr    - highest-priority index; the search runs upward from here and wraps
//   en     - when low no grant is issued (gnt = 0, any = 0)
//   gnt    - one-hot grant, or zero
//   gnt_id - index of the first requester found (meaningful when any = 1)
//   any    - a grant is being issued
module rr_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned IdW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  input  logic [IdW-1:0] ptr,
  input  logic           en,
  output logic [N-1:0]   gnt,
  output logic [IdW-1:0] gnt_id,
  output logic           any
);

  always_comb begin
    logic           found;
    logic [IdW-1:0] id;
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    found  = 1'b0;
    id     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      id = IdW'((32'(ptr) + k) % N);
      if (!found && req[id]) begin
        found  = 1'b1;
        gnt_id = id;
      end
    end
    if (en && found) begin
      gnt[gnt_id] = 1'b1;
      any         = 1'b1;
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one external combinational multiplier between NUM_REQ requesters.
// Two register stages: S1 holds the granted operands (driving mul_a/mul_b),
// S2 captures mul_m and presents it on the rsp_* channel. Latency is 2 cycles
// from accept to rsp_valid; throughput is one product per cycle.
// Operand/product widths come from mul_arb_pkg.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   req_valid/req_ready   - per-requester handshake; req_ready is the grant
//   req_a/req_b           - per-requester operands
//   mul_a/mul_b/mul_m     - to/from the external multiplier
//   rsp_valid/rsp_ready   - response handshake
//   rsp_id/rsp_m          - issuing requester and its product (unnormalized)
// Optional: define MUL_ARBITER_PERF_EN to add saturating perf_busy/perf_stall counters.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic [NUM_REQ-1:0]                              req_valid,
  output logic [NUM_REQ-1:0]                              req_ready,
  input  logic [NUM_REQ-1:0][NUM_ELEMENTS-1:0][BIT_LEN-1:0] req_a,
  input  logic [NUM_REQ-1:0][NUM_ELEMENTS-1:0][BIT_LEN-1:0] req_b,
  output logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]            mul_a,
  output logic [NUM_ELEMENTS-1:0][BIT_LEN-1:0]            mul_b,
  input  logic [NUM_OUT-1:0][BIT_LEN-1:0]                 mul_m,
  output logic                                            rsp_valid,
  input  logic                                            rsp_ready,
  output logic [ID_W-1:0]                                 rsp_id,
  output logic [NUM_OUT-1:0][BIT_LEN-1:0]                 rsp_m
`ifdef MUL_ARBITER_PERF_EN
  ,
  output logic [31:0]                                     perf_busy,
  output logic [31:0]                                     perf_stall
`endif
);

  operand_t        s1_a_q, s1_b_q;
  logic [ID_W-1:0] s1_id_q, s2_id_q, ptr_q;
  logic            s1_v_q, s2_v_q;
  product_t        s2_m_q;

  logic            stall2, adv1, issue_en, any;
  logic [ID_W-1:0] gnt_id, ptr_nxt;

  assign stall2  = s2_v_q & ~rsp_ready;
  assign adv1    = ~stall2;
  // S1 only refills when the pipe advances, so an empty S1 also waits out an
  // S2 stall; this keeps S1, S2 and ptr frozen while the consumer holds off.
  assign issue_en = adv1 & ~rst;
  assign ptr_nxt  = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;

  rr_arbiter #(
    .N   (NUM_REQ),
    .IdW (ID_W)
  ) u_rr (
    .req    (req_valid),
    .ptr    (ptr_q),
    .en     (issue_en),
    .gnt    (req_ready),
    .gnt_id (gnt_id),
    .any    (any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q  <= 1'b0;
      s1_a_q  <= '0;
      s1_b_q  <= '0;
      s1_id_q <= '0;
      s2_v_q  <= 1'b0;
      s2_m_q  <= '0;
      s2_id_q <= '0;
      ptr_q   <= '0;
    end else if (adv1) begin
      s2_v_q <= s1_v_q;
      // Hold the last product when S1 is empty to avoid needless toggling.
      if (s1_v_q) begin
        s2_m_q  <= mul_m;
        s2_id_q <= s1_id_q;
      end
      s1_v_q <= any;
      if (any) begin
        s1_a_q  <= req_a[gnt_id];
        s1_b_q  <= req_b[gnt_id];
        s1_id_q <= gnt_id;
        ptr_q   <= ptr_nxt;
      end
    end
  end

  assign mul_a     = s1_a_q;
  assign mul_b     = s1_b_q;
  assign rsp_valid = s2_v_q;
  assign rsp_id    = s2_id_q;
  assign rsp_m     = s2_m_q;

`ifdef MUL_ARBITER_PERF_EN
  logic [31:0] busy_q, stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      stall_q <= '0;
    end else begin
      if ((s1_v_q | s2_v_q) && (busy_q != '1)) busy_q <= busy_q + 32'd1;
      if (stall2 && (stall_q != '1))           stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_busy  = busy_q;
  assign perf_stall = stall_q;
`endif

endmodule
